// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM encoding and datapath widths.
package alu_ctrl_pkg;

   localparam int OPW  = 8;
   localparam int RESW = 16;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_MOD = 3'd4;
   localparam logic [2:0] OP_EQ  = 3'd5;
   localparam logic [2:0] OP_GT  = 3'd6;
   localparam logic [2:0] OP_LT  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic div_by_zero(input logic [2:0] op, input logic [OPW-1:0] b);
      return ((op == OP_DIV) || (op == OP_MOD)) && (b == '0);
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two requesters and the ALU arbiter.
interface alu_arbiter_if;
   import alu_ctrl_pkg::*;

   logic            req0_valid, req0_ready;
   logic [OPW-1:0]  req0_a, req0_b;
   logic [2:0]      req0_op;
   logic            req1_valid, req1_ready;
   logic [OPW-1:0]  req1_a, req1_b;
   logic [2:0]      req1_op;
   logic            rsp0_valid, rsp0_ready;
   logic            rsp1_valid, rsp1_ready;
   logic [RESW-1:0] rsp_result;
   logic            rsp_dz;
   logic            busy;

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      output rsp0_ready, rsp1_ready,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
      input  rsp_result, rsp_dz, busy
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      input  rsp0_ready, rsp1_ready,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
      output rsp_result, rsp_dz, busy
   );

endinterface

// File: rtl/ALU.sv
// Shared combinational ALU; output is forced to zero whenever ena is low.
module ALU
   import alu_ctrl_pkg::*;
(
   input  logic            ena,
   input  logic [OPW-1:0]  a,
   input  logic [OPW-1:0]  b,
   input  logic [2:0]      op,
   output logic [RESW-1:0] result
);

   logic [OPW-1:0] diff;
   assign diff = a - b;

   always_comb begin
      result = '0;
      if (ena) begin
         case (op)
            OP_ADD:  result = RESW'(a) + RESW'(b);
            OP_SUB:  result = RESW'(diff);
            OP_MUL:  result = RESW'(a) * RESW'(b);
            OP_DIV:  result = (b == '0) ? '0 : RESW'(a / b);
            OP_MOD:  result = (b == '0) ? '0 : RESW'(a % b);
            OP_EQ:   result = RESW'(a == b);
            OP_GT:   result = RESW'(a > b);
            default: result = RESW'(a < b);
         endcase
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front-end for the shared ALU: arbitrate, capture operands,
// run the ALU for one cycle, and hold the result until the winner takes it.
module alu_arbiter
   import alu_ctrl_pkg::*;
#(
   parameter bit RR_ENABLE = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   alu_arbiter_if.slave bus
);

   state_t          state;
   logic            last_grant, grant_id, gnt;
   logic [OPW-1:0]  op_a, op_b;
   logic [2:0]      op_code;
   logic [RESW-1:0] alu_res, rsp_result_q;
   logic            alu_ena, rsp_dz_q, rsp0_valid_q, rsp1_valid_q, busy_q;
   logic            accept, rsp_done;

   // A lone request always wins; a tie goes to req0 unless round-robin says otherwise.
   always_comb begin
      gnt = ~bus.req0_valid;
      if (RR_ENABLE && bus.req0_valid && bus.req1_valid)
         gnt = ~last_grant;
   end

   assign bus.req0_ready = (state == ST_IDLE) && !gnt && bus.req0_valid;
   assign bus.req1_ready = (state == ST_IDLE) &&  gnt && bus.req1_valid;
   assign accept   = bus.req0_ready || bus.req1_ready;
   assign rsp_done = grant_id ? bus.rsp1_ready : bus.rsp0_ready;
   assign alu_ena  = (state == ST_EXEC);

   ALU u_alu (
      .ena    (alu_ena),
      .a      (op_a),
      .b      (op_b),
      .op     (op_code),
      .result (alu_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         last_grant   <= 1'b1;
         grant_id     <= 1'b0;
         op_a         <= '0;
         op_b         <= '0;
         op_code      <= '0;
         rsp_result_q <= '0;
         rsp_dz_q     <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_a     <= gnt ? bus.req1_a  : bus.req0_a;
                  op_b     <= gnt ? bus.req1_b  : bus.req0_b;
                  op_code  <= gnt ? bus.req1_op : bus.req0_op;
                  grant_id <= gnt;
                  busy_q   <= 1'b1;
                  state    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rsp_result_q <= alu_res;
               rsp_dz_q     <= div_by_zero(op_code, op_b);
               rsp0_valid_q <= ~grant_id;
               rsp1_valid_q <=  grant_id;
               state        <= ST_RESP;
            end
            ST_RESP: begin
               // Only the owning requester's ready can complete the response.
               if (rsp_done) begin
                  rsp0_valid_q <= 1'b0;
                  rsp1_valid_q <= 1'b0;
                  busy_q       <= 1'b0;
                  last_grant   <= grant_id;
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_dz     = rsp_dz_q;
   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.busy       = busy_q;

endmodule
